// File: rtl/idt_cfg_pkg.sv
// ---------------------------------------------------------------------------
// idt_cfg_pkg
// Shared definitions for the IDT clock-synthesiser configuration sequencer:
// the FSM state type, the bit positions and widths of each field in the
// 24-bit configuration word, the default power-up word, and a helper that
// assembles a word from its fields.
// No ports (package).
// ---------------------------------------------------------------------------
package idt_cfg_pkg;

    localparam int CFG_W = 24;

    // Field layout: {C[23:22], TTL[21], F[20:19], S[18:16], V[15:7], R[6:0]}
    localparam int C_LSB   = 22;
    localparam int C_W     = 2;
    localparam int TTL_BIT = 21;
    localparam int F_LSB   = 19;
    localparam int F_W     = 2;
    localparam int S_LSB   = 16;
    localparam int S_W     = 3;
    localparam int V_LSB   = 7;
    localparam int V_W     = 9;
    localparam int R_LSB   = 0;
    localparam int R_W     = 7;

    localparam logic [CFG_W-1:0] BOOT_CFG_DEFAULT = 24'h1A_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_STROBE = 2'd2,
        ST_SETTLE = 2'd3
    } cfg_state_t;

    function automatic logic [CFG_W-1:0] pack_cfg(
        input logic [C_W-1:0] c,
        input logic           ttl,
        input logic [F_W-1:0] f,
        input logic [S_W-1:0] s,
        input logic [V_W-1:0] v,
        input logic [R_W-1:0] r
    );
        logic [CFG_W-1:0] w;
        w = '0;
        w[C_LSB +: C_W] = c;
        w[TTL_BIT]      = ttl;
        w[F_LSB +: F_W] = f;
        w[S_LSB +: S_W] = s;
        w[V_LSB +: V_W] = v;
        w[R_LSB +: R_W] = r;
        return w;
    endfunction

endpackage

// File: rtl/idt_cfg_shifter.sv
// ---------------------------------------------------------------------------
// idt_cfg_shifter
// Serialises a 24-bit configuration word MSB first. Each bit holds idt_sclk
// low for SCLK_DIV cycles and then high for SCLK_DIV cycles; idt_data only
// moves on the falling transition so it is stable across every rising edge.
// Ports:
//   osc_clk, osc_reset_  clock, asynchronous active-low reset
//   load                 capture word (first bit appears next cycle)
//   run                  advance the divider/bit counter (FSM is in SHIFT)
//   word[23:0]           word to capture on load
//   idt_sclk, idt_data   registered serial outputs
//   last_bit             high on the edge that ends the final high phase
// ---------------------------------------------------------------------------
module idt_cfg_shifter
    import idt_cfg_pkg::*;
#(
    parameter int               SCLK_DIV   = 1,
    parameter logic [CFG_W-1:0] RESET_WORD = BOOT_CFG_DEFAULT
) (
    input  logic             osc_clk,
    input  logic             osc_reset_,
    input  logic             load,
    input  logic             run,
    input  logic [CFG_W-1:0] word,
    output logic             idt_sclk,
    output logic             idt_data,
    output logic             last_bit
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = $clog2(CFG_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_W - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    // idt_data is the MSB of the shift register; rest holds the bits still
    // to be sent, so the 24-bit register is {idt_data, rest}.
    logic [CFG_W-2:0] rest;
    logic             div_end;

    assign div_end  = (div_cnt == DIV_LAST);
    assign last_bit = run & idt_sclk & div_end & (bit_cnt == BIT_LAST);

    // The reset value of rest only matters when the sequencer boots straight
    // into SHIFT; the MSB is forced to 0 during reset, so a boot word is
    // expected to carry 0 in bit 23.
    always_ff @(posedge osc_clk or negedge osc_reset_) begin
        if (!osc_reset_) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            idt_sclk <= 1'b0;
            idt_data <= 1'b0;
            rest     <= RESET_WORD[CFG_W-2:0];
        end else if (load) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            idt_sclk <= 1'b0;
            idt_data <= word[CFG_W-1];
            rest     <= word[CFG_W-2:0];
        end else if (run) begin
            if (div_end) begin
                div_cnt <= '0;
                if (!idt_sclk) begin
                    idt_sclk <= 1'b1;
                end else begin
                    idt_sclk <= 1'b0;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        idt_data <= 1'b0;
                        rest     <= '0;
                    end else begin
                        bit_cnt  <= bit_cnt + BIT_W'(1);
                        idt_data <= rest[CFG_W-2];
                        rest     <= {rest[CFG_W-3:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end else begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            idt_sclk <= 1'b0;
            idt_data <= 1'b0;
        end
    end

endmodule

// File: rtl/idt_cfg_seq.sv
// ---------------------------------------------------------------------------
// idt_cfg_seq
// Loads a 24-bit configuration word into an IDT clock synthesiser: shifts it
// out serially, pulses the load strobe for 2*SCLK_DIV cycles, then waits
// SETTLE_CYCLES for the PLL to lock before pulsing done.
// Optional feature: define IDT_CFG_BOOT_EN to shift BOOT_CFG out of reset
// without any request (FSM resets into SHIFT with busy=1, cfg_ready=0).
// Ports:
//   osc_clk, osc_reset_   clock, asynchronous active-low reset
//   cfg_valid, cfg_data   request handshake and word; accepted when cfg_ready
//   cfg_ready             high only in IDLE
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse in the first IDLE cycle after settle
//   idt_sclk, idt_data    serial clock / data to the IDT part
//   idt_strobe            load strobe to the IDT part
// ---------------------------------------------------------------------------
module idt_cfg_seq
    import idt_cfg_pkg::*;
#(
    parameter int               SCLK_DIV      = 1,
    parameter int               SETTLE_CYCLES = 1024,
    parameter logic [CFG_W-1:0] BOOT_CFG      = BOOT_CFG_DEFAULT
) (
    input  logic             osc_clk,
    input  logic             osc_reset_,
    input  logic             cfg_valid,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             cfg_ready,
    output logic             busy,
    output logic             done,
    output logic             idt_sclk,
    output logic             idt_data,
    output logic             idt_strobe
);

    localparam int STROBE_W = $clog2(2 * SCLK_DIV);
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [STROBE_W-1:0] STROBE_LAST = STROBE_W'(2 * SCLK_DIV - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

`ifdef IDT_CFG_BOOT_EN
    localparam cfg_state_t RESET_STATE = ST_SHIFT;
    localparam logic       RESET_BUSY  = 1'b1;
`else
    localparam cfg_state_t RESET_STATE = ST_IDLE;
    localparam logic       RESET_BUSY  = 1'b0;
`endif

    cfg_state_t           state;
    logic [STROBE_W-1:0]  strobe_cnt;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic                 accept;
    logic                 last_bit;

    // Ready is a pure decode of the state register so it follows reset
    // immediately and rises together with done.
    assign cfg_ready = (state == ST_IDLE);
    assign accept    = cfg_valid & cfg_ready;

    idt_cfg_shifter #(
        .SCLK_DIV   (SCLK_DIV),
        .RESET_WORD (BOOT_CFG)
    ) u_shifter (
        .osc_clk    (osc_clk),
        .osc_reset_ (osc_reset_),
        .load       (accept),
        .run        (state == ST_SHIFT),
        .word       (cfg_data),
        .idt_sclk   (idt_sclk),
        .idt_data   (idt_data),
        .last_bit   (last_bit)
    );

    always_ff @(posedge osc_clk or negedge osc_reset_) begin
        if (!osc_reset_) begin
            state      <= RESET_STATE;
            busy       <= RESET_BUSY;
            done       <= 1'b0;
            idt_strobe <= 1'b0;
            strobe_cnt <= '0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_SHIFT;
                        busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        state      <= ST_STROBE;
                        idt_strobe <= 1'b1;
                        strobe_cnt <= '0;
                    end
                end
                ST_STROBE: begin
                    if (strobe_cnt == STROBE_LAST) begin
                        state      <= ST_SETTLE;
                        idt_strobe <= 1'b0;
                        settle_cnt <= '0;
                    end else begin
                        strobe_cnt <= strobe_cnt + STROBE_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    idt_strobe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idt_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_idt_cfg_seq
// Self-checking bench for idt_cfg_seq. Two instances share clock and reset:
// dut_a with SCLK_DIV=1 and dut_b with SCLK_DIV=3, both SETTLE_CYCLES=16.
// Every cycle of every load is compared against a waveform computed directly
// from the cycle position after the accepting edge.
// ---------------------------------------------------------------------------
module tb_idt_cfg_seq;
    import idt_cfg_pkg::*;

    localparam int DIV_A  = 1;
    localparam int DIV_B  = 3;
    localparam int SETTLE = 16;

    // Observed/expected vector layout: {cfg_ready, busy, done, sclk, data, strobe}
    localparam logic [5:0] IDLE_VEC = 6'b100000;
`ifdef IDT_CFG_BOOT_EN
    localparam logic [5:0] RESET_VEC = 6'b010000;
`else
    localparam logic [5:0] RESET_VEC = 6'b100000;
`endif

    logic        osc_clk;
    logic        osc_reset_;
    logic        cfg_valid_a, cfg_valid_b;
    logic [23:0] cfg_data_a, cfg_data_b;
    logic        cfg_ready_a, busy_a, done_a, idt_sclk_a, idt_data_a, idt_strobe_a;
    logic        cfg_ready_b, busy_b, done_b, idt_sclk_b, idt_data_b, idt_strobe_b;

    int checks   = 0;
    int failures = 0;

    idt_cfg_seq #(
        .SCLK_DIV      (DIV_A),
        .SETTLE_CYCLES (SETTLE),
        .BOOT_CFG      (24'h1A0000)
    ) dut_a (
        .osc_clk    (osc_clk),
        .osc_reset_ (osc_reset_),
        .cfg_valid  (cfg_valid_a),
        .cfg_data   (cfg_data_a),
        .cfg_ready  (cfg_ready_a),
        .busy       (busy_a),
        .done       (done_a),
        .idt_sclk   (idt_sclk_a),
        .idt_data   (idt_data_a),
        .idt_strobe (idt_strobe_a)
    );

    idt_cfg_seq #(
        .SCLK_DIV      (DIV_B),
        .SETTLE_CYCLES (SETTLE),
        .BOOT_CFG      (24'h1A0000)
    ) dut_b (
        .osc_clk    (osc_clk),
        .osc_reset_ (osc_reset_),
        .cfg_valid  (cfg_valid_b),
        .cfg_data   (cfg_data_b),
        .cfg_ready  (cfg_ready_b),
        .busy       (busy_b),
        .done       (done_b),
        .idt_sclk   (idt_sclk_b),
        .idt_data   (idt_data_b),
        .idt_strobe (idt_strobe_b)
    );

    // Free-running clock, period 10; outputs are sampled on the falling edge.
    initial begin
        osc_clk = 1'b0;
        forever #5 osc_clk = ~osc_clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int divOf(input int sel);
        return (sel == 0) ? DIV_A : DIV_B;
    endfunction

    function automatic logic [5:0] observe(input int sel);
        if (sel == 0)
            return {cfg_ready_a, busy_a, done_a, idt_sclk_a, idt_data_a, idt_strobe_a};
        return {cfg_ready_b, busy_b, done_b, idt_sclk_b, idt_data_b, idt_strobe_b};
    endfunction

    // Expected outputs k cycles after the accepting edge (k=1 is the first
    // cycle after it): 24 bits of 2*div cycles each, low half then high half,
    // then a 2*div strobe, then the settle wait, then the done cycle.
    function automatic logic [5:0] expVec(input int div, input int settle,
                                          input logic [23:0] w, input int k);
        int pos;
        int idx;
        if (k <= 48 * div) begin
            pos = (k - 1) % (2 * div);
            idx = (k - 1) / (2 * div);
            return {1'b0, 1'b1, 1'b0, (pos >= div), w[23 - idx], 1'b0};
        end
        if (k <= 50 * div)          return 6'b010001;
        if (k <= 50 * div + settle) return 6'b010000;
        return 6'b101000;
    endfunction

    task automatic checkOutput(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic valid, input logic [23:0] data);
        if (sel == 0) begin
            cfg_valid_a = valid;
            cfg_data_a  = data;
        end else begin
            cfg_valid_b = valid;
            cfg_data_b  = data;
        end
    endtask

    // Runs one complete load and checks every cycle up to and including done.
    // Unless chained, the request is raised here (we sit at a falling edge
    // with cfg_ready high). Right after the accept, cfg_data is replaced
    // either by the next word (held with cfg_valid through busy) or by junk.
    task automatic doLoad(input int sel, input logic [23:0] word, input bit chained,
                          input bit keep, input logic [23:0] next_word);
        int div;
        int len;
        div = divOf(sel);
        len = 50 * div + SETTLE + 1;
        if (!chained) applyStimulus(sel, 1'b1, word);
        for (int k = 1; k <= len; k++) begin
            @(negedge osc_clk);
            checkOutput($sformatf("dut%0d w=%06h cyc%0d", sel, word, k),
                        observe(sel), expVec(div, SETTLE, word, k));
            if (k == 1) applyStimulus(sel, keep, keep ? next_word : 24'($urandom));
        end
    endtask

    // Applies reset, checks the in-reset outputs, releases, then either
    // watches the idle outputs or (boot build) times the boot load.
    task automatic doReset(input int idle_cycles);
        osc_reset_ = 1'b0;
        applyStimulus(0, 1'b0, 24'h0);
        applyStimulus(1, 1'b0, 24'h0);
        repeat (2) @(negedge osc_clk);
        checkOutput("in_reset_a", observe(0), RESET_VEC);
        checkOutput("in_reset_b", observe(1), RESET_VEC);
        osc_reset_ = 1'b1;
`ifdef IDT_CFG_BOOT_EN
        begin
            int done_at_a;
            int done_at_b;
            done_at_a = -1;
            done_at_b = -1;
            for (int n = 1; n <= 200; n++) begin
                @(negedge osc_clk);
                if (done_a && done_at_a < 0) done_at_a = n;
                if (done_b && done_at_b < 0) done_at_b = n;
            end
            checkCount("boot_done_a", done_at_a, 50 * DIV_A + SETTLE);
            checkCount("boot_done_b", done_at_b, 50 * DIV_B + SETTLE);
        end
`else
        for (int n = 1; n <= idle_cycles; n++) begin
            @(negedge osc_clk);
            checkOutput($sformatf("idle_a cyc%0d", n), observe(0), IDLE_VEC);
            checkOutput($sformatf("idle_b cyc%0d", n), observe(1), IDLE_VEC);
        end
`endif
    endtask

    // Directed sequence: reset, the reference word, a held second request,
    // random and corner words on both dividers, then reset in mid-shift.
    initial begin
        logic [23:0] w;
        osc_reset_  = 1'b0;
        cfg_valid_a = 1'b0;
        cfg_valid_b = 1'b0;
        cfg_data_a  = 24'h0;
        cfg_data_b  = 24'h0;

        doReset(3);

        doLoad(0, 24'hA50F3C, 1'b0, 1'b1, 24'h001234);
        doLoad(0, 24'h001234, 1'b1, 1'b0, 24'h0);
        repeat (3) doLoad(0, 24'($urandom), 1'b0, 1'b0, 24'h0);
        doLoad(0, pack_cfg(2'($urandom), 1'($urandom), 2'($urandom), 3'($urandom),
                           9'($urandom), 7'($urandom)), 1'b0, 1'b0, 24'h0);
        doLoad(0, 24'hFFFFFF, 1'b0, 1'b0, 24'h0);
        doLoad(0, 24'h800001, 1'b0, 1'b0, 24'h0);

        doLoad(1, 24'hA50F3C, 1'b0, 1'b0, 24'h0);
        doLoad(1, 24'($urandom), 1'b0, 1'b1, 24'h5A5A5A);
        doLoad(1, 24'h5A5A5A, 1'b1, 1'b0, 24'h0);

        // Reset during the high phase of bit 10 (bit 13 of the word, set to 1).
        w = 24'($urandom) | 24'h002000;
        applyStimulus(0, 1'b1, w);
        for (int k = 1; k <= 22; k++) begin
            @(negedge osc_clk);
            checkOutput($sformatf("pre_reset w=%06h cyc%0d", w, k),
                        observe(0), expVec(DIV_A, SETTLE, w, k));
            if (k == 1) applyStimulus(0, 1'b0, 24'($urandom));
        end
        osc_reset_ = 1'b0;
        #1;
        checkOutput("reset_mid_shift", observe(0), RESET_VEC);
        doReset(70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
